qlearn_tables: RTL and testbench
================================

Name: qlearn_tables

Overview:
- Storage block for the Q-learning accelerator pipeline. It holds three tables:
  - Q table: one value per state-action pair, 256 entries.
  - Qmax table: best value per state, 64 entries.
  - R table: read-only rewards.
- Each table has registered, one-cycle-latency reads. Q and Qmax are one-read/one-write RAMs that are cleared by a hardware sweep after reset.
- The block sits beside the pipeline's fetch stages (Q, R, Qmax read) and its write-back stage (Q and Qmax write).

Parameters:
- DATA_WIDTH, 8, width of Q, Qmax and R values; unsigned Q4.4 fixed point.
- Q_AW, 8, Q table address width; address is {state[5:0], action[1:0]}; depth 2^Q_AW.
- QMAX_AW, 6, Qmax table address width (state); depth 2^QMAX_AW.
- R_AW, 8, R table address width.
- GOAL_STATE, 63, R table address that holds the goal reward.
- GOAL_REWARD, 8'h10, reward at GOAL_STATE (1.0 in Q4.4).

Ports:
- i_clk, in, 1, single clock; all logic on rising edge.
- i_rst, in, 1, asynchronous active-high reset.
- i_q_addr_r, in, Q_AW, Q table read address.
- i_q_addr_w, in, Q_AW, Q table write address.
- i_q_we, in, 1, Q table write enable.
- i_q_data, in, DATA_WIDTH, Q table write data.
- o_q_data, out, DATA_WIDTH, Q table registered read data.
- i_qmax_addr_r, in, QMAX_AW, Qmax table read address.
- i_qmax_addr_w, in, QMAX_AW, Qmax table write address.
- i_qmax_we, in, 1, Qmax table write enable.
- i_qmax_data, in, DATA_WIDTH, Qmax table write data.
- o_qmax_data, out, DATA_WIDTH, Qmax table registered read data.
- i_r_addr, in, R_AW, R table read address.
- i_r_read, in, 1, R table read enable.
- o_r_data, out, DATA_WIDTH, R table registered read data.
- o_init_busy, out, 1, high while the post-reset clear sweep runs.

Behaviour:
- Reset (async, i_rst=1):
  - o_q_data, o_qmax_data and o_r_data go to 0 immediately.
  - o_init_busy goes to 1.
  - Sweep counter goes to 0.
  - Memory arrays are not reset asynchronously.
- Clear sweep (first i_clk edge after i_rst deasserts onward):
  - Each cycle, write 0 to Q[cnt] and, while cnt < 2^QMAX_AW, to Qmax[cnt]; then increment cnt.
  - After Q entry 2^Q_AW-1 is written, o_init_busy drops to 0 on that same edge: 256 cycles at defaults.
  - i_q_we and i_qmax_we are ignored while busy.
  - Q and Qmax outputs are forced to 0 while busy.
  - Reset asserted mid-sweep restarts the sweep from 0.
- Q read: on each edge when not busy, o_q_data <= Q[i_q_addr_r]. Latency 1 cycle; no read enable.
- Q write: on an edge with i_q_we=1 and not busy, Q[i_q_addr_w] <= i_q_data.
- Read-during-write, same address, same edge: read-first. The output shows the old data; the new data is visible from the next read.
- Qmax table: identical rules, with QMAX_AW-wide addresses.
- R table:
  - Content is combinational: GOAL_REWARD when i_r_addr == GOAL_STATE, else 0.
  - On an edge with i_r_read=1, o_r_data <= that content.
  - When i_r_read=0, o_r_data holds its value.
  - The R table is independent of o_init_busy.
- Width rules:
  - Addresses are used unextended and unwrapped; every address value maps to a distinct entry (full decode).
  - Data is stored bit-exact; no saturation or arithmetic inside the block.
- Q and Qmax can be written on the same edge to different tables; there is no cross-table interaction.
- Outputs change only on i_clk edges or on reset assertion.

Decomposition:
- Package qlearn_tables_pkg:
  - DATA_WIDTH, Q_AW, QMAX_AW, R_AW default constants.
  - GOAL_STATE and GOAL_REWARD constants.
  - Action encoding constants: LEFT=0, UP=1, RIGHT=2, DOWN=3.
  - Typedefs: state (6 bits), action (2 bits), q_addr = {state, action}.
- Sub-module tbl_ram_1r1w (parameters AW, DW):
  - Registered read-first read; write enable; async-reset output register; force-zero input.
  - Instantiated twice (Q and Qmax).
- The clear sweep and the R table stay in the top level.

Test Plan:
- Reset then idle: o_init_busy=1 for exactly 256 cycles after deassert, then 0. Afterwards read Q addresses 0x00, 0x87, 0xFF and Qmax addresses 0x00, 0x3F -> all return 8'h00 one cycle after the address is applied.
- Write/read: Q[0x85]=8'h23 and Qmax[0x21]=8'h19; next cycle read both -> o_q_data=8'h23 and o_qmax_data=8'h19 after 1-cycle latency. Neighbour Q[0x84] stays 8'h00.
- Same-address read/write on one edge: Q[0x10]=8'h05, then write 8'h07 to 0x10 while reading 0x10 -> output 8'h05 on that cycle, 8'h07 on the following read.
- Writes during busy: i_q_we=1 to 0x01 with data 8'hAA while o_init_busy=1 -> after the sweep, Q[0x01] reads 8'h00.
- R table:
  - i_r_addr=63 with i_r_read=1 -> o_r_data=8'h10 next cycle.
  - Address 33 -> 8'h00.
  - With i_r_read=0 and address 63 -> o_r_data holds its prior value.
- Async reset mid-operation: assert i_rst between clock edges after writing Q[0x05]=8'h33 -> all outputs go to 0 immediately and o_init_busy=1. After the sweep, Q[0x05] reads 8'h00.

Source files
------------

// File: rtl/qlearn_tables_pkg.sv
// Shared constants and address types for the Q-learning storage tables.
// Q addresses are {state, action}; Qmax and R are indexed by state.
package qlearn_tables_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int Q_AW       = 8;
    localparam int QMAX_AW    = 6;
    localparam int R_AW       = 8;

    localparam int             GOAL_STATE  = 63;
    localparam logic [7:0]     GOAL_REWARD = 8'h10;

    localparam logic [1:0] LEFT  = 2'd0;
    localparam logic [1:0] UP    = 2'd1;
    localparam logic [1:0] RIGHT = 2'd2;
    localparam logic [1:0] DOWN  = 2'd3;

    typedef logic [5:0] state_t;
    typedef logic [1:0] action_t;

    typedef struct packed {
        state_t  state;
        action_t action;
    } q_addr_t;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_READY = 1'b1
    } sweep_state_e;

    function automatic q_addr_t make_q_addr(state_t s, action_t a);
        q_addr_t r;
        r.state  = s;
        r.action = a;
        return r;
    endfunction

endpackage

// File: rtl/qlearn_tables_if.sv
// Pipeline-side bundle for the tables: fetch-stage reads and write-back writes.
// No handshake: reads return one cycle after the address, writes commit on the edge.
interface qlearn_tables_if;
    import qlearn_tables_pkg::*;

    logic [Q_AW-1:0]       i_q_addr_r;
    logic [Q_AW-1:0]       i_q_addr_w;
    logic                  i_q_we;
    logic [DATA_WIDTH-1:0] i_q_data;
    logic [DATA_WIDTH-1:0] o_q_data;

    logic [QMAX_AW-1:0]    i_qmax_addr_r;
    logic [QMAX_AW-1:0]    i_qmax_addr_w;
    logic                  i_qmax_we;
    logic [DATA_WIDTH-1:0] i_qmax_data;
    logic [DATA_WIDTH-1:0] o_qmax_data;

    logic [R_AW-1:0]       i_r_addr;
    logic                  i_r_read;
    logic [DATA_WIDTH-1:0] o_r_data;

    logic                  o_init_busy;
    sweep_state_e          dbg_state;

    modport master (
        output i_q_addr_r, i_q_addr_w, i_q_we, i_q_data,
        output i_qmax_addr_r, i_qmax_addr_w, i_qmax_we, i_qmax_data,
        output i_r_addr, i_r_read,
        input  o_q_data, o_qmax_data, o_r_data, o_init_busy, dbg_state
    );

    modport slave (
        input  i_q_addr_r, i_q_addr_w, i_q_we, i_q_data,
        input  i_qmax_addr_r, i_qmax_addr_w, i_qmax_we, i_qmax_data,
        input  i_r_addr, i_r_read,
        output o_q_data, o_qmax_data, o_r_data, o_init_busy, dbg_state
    );

endinterface

// File: rtl/tbl_ram_1r1w.sv
// One-read/one-write RAM with a registered, read-first output.
// The array itself is never reset; only the read register is.
module tbl_ram_1r1w #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          force_zero,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Sampling mem on the same edge as the write gives read-first behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (force_zero) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/qlearn_tables.sv
// Q, Qmax and R tables for the Q-learning pipeline, with a post-reset clear
// sweep that zeroes Q and Qmax before the pipeline may use them.
module qlearn_tables
    import qlearn_tables_pkg::*;
#(
    parameter int DATA_WIDTH_P = DATA_WIDTH,
    parameter int Q_AW_P       = Q_AW,
    parameter int QMAX_AW_P    = QMAX_AW,
    parameter int R_AW_P       = R_AW
) (
    input  logic           i_clk,
    input  logic           i_rst,
    qlearn_tables_if.slave bus
);

    sweep_state_e            state_q, state_d;
    logic [Q_AW_P-1:0]       cnt_q, cnt_d;
    logic                    busy;

    logic                    q_we;
    logic [Q_AW_P-1:0]       q_waddr;
    logic [DATA_WIDTH_P-1:0] q_wdata;
    logic                    qmax_we;
    logic [QMAX_AW_P-1:0]    qmax_waddr;
    logic [DATA_WIDTH_P-1:0] qmax_wdata;
    logic [DATA_WIDTH_P-1:0] r_content;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_SWEEP) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {Q_AW_P{1'b1}}) begin
                state_d = ST_READY;
            end
        end
    end

    assign busy = (state_q == ST_SWEEP);

    // The sweep owns both write ports while busy; Qmax only covers its smaller range.
    assign q_we       = busy | bus.i_q_we;
    assign q_waddr    = busy ? cnt_q : bus.i_q_addr_w;
    assign q_wdata    = busy ? '0 : bus.i_q_data;
    assign qmax_we    = busy ? (cnt_q[Q_AW_P-1:QMAX_AW_P] == '0) : bus.i_qmax_we;
    assign qmax_waddr = busy ? cnt_q[QMAX_AW_P-1:0] : bus.i_qmax_addr_w;
    assign qmax_wdata = busy ? '0 : bus.i_qmax_data;

    tbl_ram_1r1w #(.AW(Q_AW_P), .DW(DATA_WIDTH_P)) u_q_ram (
        .clk        (i_clk),
        .rst        (i_rst),
        .force_zero (busy),
        .we         (q_we),
        .waddr      (q_waddr),
        .wdata      (q_wdata),
        .raddr      (bus.i_q_addr_r),
        .rdata      (bus.o_q_data)
    );

    tbl_ram_1r1w #(.AW(QMAX_AW_P), .DW(DATA_WIDTH_P)) u_qmax_ram (
        .clk        (i_clk),
        .rst        (i_rst),
        .force_zero (busy),
        .we         (qmax_we),
        .waddr      (qmax_waddr),
        .wdata      (qmax_wdata),
        .raddr      (bus.i_qmax_addr_r),
        .rdata      (bus.o_qmax_data)
    );

    // Rewards are fixed: only the goal state pays out.
    assign r_content = (bus.i_r_addr == R_AW_P'(GOAL_STATE)) ? DATA_WIDTH_P'(GOAL_REWARD) : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_r_data <= '0;
        end else if (bus.i_r_read) begin
            bus.o_r_data <= r_content;
        end
    end

    assign bus.o_init_busy = busy;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_qlearn_tables.sv
// Self-checking bench for qlearn_tables: vector table, hand-written reset and
// sweep sequences, and a random phase checked against a small table model.
module tb_qlearn_tables;
  import qlearn_tables_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  qlearn_tables_if bus ();

  qlearn_tables dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       q_we;
    logic [7:0] q_aw;
    logic [7:0] q_d;
    logic [7:0] q_ar;
    logic       qm_we;
    logic [5:0] qm_aw;
    logic [7:0] qm_d;
    logic [5:0] qm_ar;
    logic       r_rd;
    logic [7:0] r_a;
    logic [7:0] exp_q;
    logic [7:0] exp_qm;
    logic [7:0] exp_r;
  } vec_t;

  vec_t vecs[12];

  logic [23:0] exp_q[$];
  logic [7:0]  q_model[256];
  logic [7:0]  qm_model[64];
  logic [7:0]  r_model;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) q_model[i] = 8'h00;
    for (int i = 0; i < 64; i++) qm_model[i] = 8'h00;
    r_model = 8'h00;
  endtask

  task automatic idle();
    bus.i_q_we = 1'b0; bus.i_q_addr_w = '0; bus.i_q_data = '0; bus.i_q_addr_r = '0;
    bus.i_qmax_we = 1'b0; bus.i_qmax_addr_w = '0; bus.i_qmax_data = '0; bus.i_qmax_addr_r = '0;
    bus.i_r_read = 1'b0; bus.i_r_addr = '0;
  endtask

  // Drive one cycle of stimulus; mexp is what the model predicts after the edge.
  task automatic drive(input logic qwe, input logic [7:0] qaw, input logic [7:0] qd,
                       input logic [7:0] qar, input logic qmwe, input logic [5:0] qmaw,
                       input logic [7:0] qmd, input logic [5:0] qmar, input logic rrd,
                       input logic [7:0] ra, output logic [23:0] mexp);
    logic [7:0] rr;
    bus.i_q_we = qwe; bus.i_q_addr_w = qaw; bus.i_q_data = qd; bus.i_q_addr_r = qar;
    bus.i_qmax_we = qmwe; bus.i_qmax_addr_w = qmaw; bus.i_qmax_data = qmd;
    bus.i_qmax_addr_r = qmar; bus.i_r_read = rrd; bus.i_r_addr = ra;
    rr = rrd ? ((ra == 8'd63) ? 8'h10 : 8'h00) : r_model;
    mexp = {q_model[qar], qm_model[qmar], rr};
    r_model = rr;
    if (qwe) q_model[qaw] = qd;
    if (qmwe) qm_model[qmaw] = qmd;
  endtask

  task automatic pop_check(input string tag);
    logic [23:0] e;
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_q"}, bus.o_q_data, e[23:16]);
      check({tag, "_qmax"}, bus.o_qmax_data, e[15:8]);
      check({tag, "_r"}, bus.o_r_data, e[7:0]);
    end
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (bus.o_init_busy && n < 400) begin
      @(posedge i_clk);
      #1;
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_q_zero"}, bus.o_q_data, 8'h00);
    check({tag, "_qmax_zero"}, bus.o_qmax_data, 8'h00);
    check({tag, "_r_zero"}, bus.o_r_data, 8'h00);
    check({tag, "_busy"}, bus.o_init_busy, 1'b1);
    check({tag, "_state"}, bus.dbg_state, ST_SWEEP);
  endtask

  initial begin
    logic [23:0] mexp;
    int          n;
    q_addr_t     qa;

    //          qwe  qaw    qd     qar    qmwe qmaw   qmd    qmar   rrd  ra     eq     eqm    er
    vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 6'h00, 8'h00, 6'h00, 1'b1, 8'd63,  8'h00, 8'h00, 8'h10};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h87, 1'b0, 6'h00, 8'h00, 6'h3F, 1'b1, 8'd33,  8'h00, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 6'h00, 8'h00, 6'h00, 1'b0, 8'd63,  8'h00, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 8'h85, 8'h23, 8'h85, 1'b1, 6'h21, 8'h19, 6'h21, 1'b1, 8'd63,  8'h00, 8'h00, 8'h10};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 8'h85, 1'b0, 6'h00, 8'h00, 6'h21, 1'b0, 8'd33,  8'h23, 8'h19, 8'h10};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 8'h84, 1'b0, 6'h00, 8'h00, 6'h20, 1'b1, 8'd0,   8'h00, 8'h00, 8'h00};
    vecs[6]  = '{1'b1, 8'h10, 8'h05, 8'h00, 1'b0, 6'h00, 8'h00, 6'h00, 1'b0, 8'd0,   8'h00, 8'h00, 8'h00};
    vecs[7]  = '{1'b1, 8'h10, 8'h07, 8'h10, 1'b1, 6'h3F, 8'hFF, 6'h3F, 1'b0, 8'd0,   8'h05, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 8'h10, 1'b0, 6'h00, 8'h00, 6'h3F, 1'b0, 8'd0,   8'h07, 8'hFF, 8'h00};
    vecs[9]  = '{1'b1, 8'hFF, 8'hA5, 8'hFF, 1'b1, 6'h00, 8'h5A, 6'h00, 1'b1, 8'd191, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 6'h00, 8'h00, 6'h00, 1'b1, 8'd63,  8'hA5, 8'h5A, 8'h10};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 8'h7F, 1'b0, 6'h00, 8'h00, 6'h01, 1'b0, 8'd0,   8'h00, 8'h00, 8'h10};

    idle();
    model_clear();
    #2 i_rst = 1'b1;
    #1 check_reset_outputs("por");
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Writes attempted through the whole sweep must be dropped.
    bus.i_q_we = 1'b1; bus.i_q_addr_w = 8'h01; bus.i_q_data = 8'hAA;
    bus.i_qmax_we = 1'b1; bus.i_qmax_addr_w = 6'h01; bus.i_qmax_data = 8'h55;
    bus.i_q_addr_r = 8'h01;
    check("busy_after_deassert", bus.o_init_busy, 1'b1);
    wait_sweep(n);
    check("sweep_cycles", n, 256);
    check("sweep_q_forced_zero", bus.o_q_data, 8'h00);
    check("state_ready", bus.dbg_state, ST_READY);
    idle();

    drive(1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 6'h00, 8'h00, 6'h01, 1'b0, 8'h00, mexp);
    exp_q.push_back(24'h000000);
    pop_check("busy_write_dropped");

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].q_we, vecs[i].q_aw, vecs[i].q_d, vecs[i].q_ar, vecs[i].qm_we,
            vecs[i].qm_aw, vecs[i].qm_d, vecs[i].qm_ar, vecs[i].r_rd, vecs[i].r_a, mexp);
      exp_q.push_back({vecs[i].exp_q, vecs[i].exp_qm, vecs[i].exp_r});
      pop_check($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 300; i++) begin
      qa = make_q_addr(6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            (i % 4 == 0) ? qa : 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)),
            6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
            (i % 3 == 0) ? 8'd63 : 8'($urandom_range(0, 255)), mexp);
      exp_q.push_back(mexp);
      pop_check("rand");
    end

    // Async reset between edges with nonzero outputs present.
    drive(1'b1, 8'h05, 8'h33, 8'h00, 1'b1, 6'h21, 8'h19, 6'h00, 1'b0, 8'h00, mexp);
    exp_q.push_back(mexp);
    pop_check("pre_rst_write");
    drive(1'b0, 8'h00, 8'h00, 8'h05, 1'b0, 6'h00, 8'h00, 6'h21, 1'b1, 8'd63, mexp);
    exp_q.push_back({8'h33, 8'h19, 8'h10});
    pop_check("pre_rst_read");
    idle();
    bus.i_q_addr_r = 8'h05;
    #3 i_rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    model_clear();
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    wait_sweep(n);
    check("sweep_cycles_after_mid_rst", n, 256);
    drive(1'b0, 8'h00, 8'h00, 8'h05, 1'b0, 6'h00, 8'h00, 6'h21, 1'b0, 8'h00, mexp);
    exp_q.push_back(24'h000000);
    pop_check("q05_cleared");

    // Reset landing in the middle of a sweep restarts the count.
    #2 i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge i_clk);
    end
    #2 i_rst = 1'b1;
    #1 check("resweep_busy", bus.o_init_busy, 1'b1);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    wait_sweep(n);
    check("sweep_cycles_restarted", n, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
